// File: rtl/aurora_rx_packet_filter.sv
// -----------------------------------------------------------------------------
// aurora_rx_packet_filter
//
// Store-and-forward filter behind the Aurora RX AXI stream (user-clock domain).
// Each frame is buffered speculatively. It is committed only when its last
// beat carries crcValid && crcPass. Frames that fail CRC, or that do not fit
// in the buffer, are rewound away whole and counted.
//
// Optional feature macro: AURORA_RX_FILTER_STATS_EN
//   defined   : pktGoodCount / pktCrcErrCount / pktOverflowCount implemented
//   undefined : counter registers omitted, count outputs tied to 0
//
// Ports
//   clk                    Aurora user clock, rising edge
//   resetN                 asynchronous active-low reset
//   sAxiStreamTdata/Tkeep  RX beat payload (stored with the entry)
//   sAxiStreamTuser        [1]=crcValid [0]=crcPass, used on tlast only
//   sAxiStreamTlast/Tvalid RX framing; the source cannot be stalled
//   mAxiStreamT*           filtered output stream with tready back-pressure
//   dropStrobe             one-cycle pulse per discarded frame
//   pkt*Count              saturating 16-bit frame counters
// -----------------------------------------------------------------------------
module aurora_rx_packet_filter #(
  parameter int ADDR_WIDTH = 9
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic [31:0] sAxiStreamTdata,
  input  logic [3:0]  sAxiStreamTkeep,
  input  logic [7:0]  sAxiStreamTuser,
  input  logic        sAxiStreamTlast,
  input  logic        sAxiStreamTvalid,
  output logic [31:0] mAxiStreamTdata,
  output logic [3:0]  mAxiStreamTkeep,
  output logic        mAxiStreamTlast,
  output logic        mAxiStreamTvalid,
  input  logic        mAxiStreamTready,
  output logic        dropStrobe,
  output logic [15:0] pktGoodCount,
  output logic [15:0] pktCrcErrCount,
  output logic [15:0] pktOverflowCount
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int PW    = ADDR_WIDTH + 1;
  localparam logic [PW-1:0] PTR_ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [PW-1:0] PTR_DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

  typedef enum logic [1:0] {
    SYNC    = 2'd0,
    ACCEPT  = 2'd1,
    DISCARD = 2'd2
  } wrState_t;

  wrState_t      state, stateNext;
  logic [36:0]   mem [DEPTH];
  logic [PW-1:0] wrPtr, wrCommit, rdPtr;
  logic [PW-1:0] wrPtrNext, wrCommitNext, fill;
  logic          full, memWe, dropNext;
  logic          goodInc, crcInc, ovfInc;
  logic [36:0]   memWrData;

  logic [36:0]   rdData, skidData;
  logic          rdValid, skidValid, rdIssue, readable, pop;
  logic [1:0]    occ;
  logic          unusedUser;

  // Only the CRC flags of tuser are meaningful here.
  assign unusedUser = ^sAxiStreamTuser[7:2];

  assign fill      = wrPtr - rdPtr;
  assign full      = (fill == PTR_DEPTH);
  assign memWrData = {sAxiStreamTlast, sAxiStreamTkeep, sAxiStreamTdata};

  // Write-side FSM next state, speculative pointer moves and frame verdicts.
  always_comb begin
    stateNext    = state;
    wrPtrNext    = wrPtr;
    wrCommitNext = wrCommit;
    memWe        = 1'b0;
    dropNext     = 1'b0;
    goodInc      = 1'b0;
    crcInc       = 1'b0;
    ovfInc       = 1'b0;
    case (state)
      SYNC: begin
        // Wait for a frame boundary; the frame in flight is never counted.
        if (sAxiStreamTvalid && sAxiStreamTlast) begin
          stateNext = ACCEPT;
        end else begin
          stateNext = SYNC;
        end
      end
      ACCEPT: begin
        if (sAxiStreamTvalid && !full) begin
          memWe     = 1'b1;
          wrPtrNext = wrPtr + PTR_ONE;
          if (sAxiStreamTlast) begin
            if (sAxiStreamTuser[1:0] == 2'b11) begin
              wrCommitNext = wrPtr + PTR_ONE;
              goodInc      = 1'b1;
            end else begin
              wrPtrNext = wrCommit;
              dropNext  = 1'b1;
              crcInc    = 1'b1;
            end
          end else begin
            wrCommitNext = wrCommit;
          end
        end else if (sAxiStreamTvalid) begin
          // Buffer full: throw away whatever of this frame was written.
          wrPtrNext = wrCommit;
          if (sAxiStreamTlast) begin
            dropNext = 1'b1;
            ovfInc   = 1'b1;
          end else begin
            stateNext = DISCARD;
          end
        end else begin
          stateNext = ACCEPT;
        end
      end
      DISCARD: begin
        if (sAxiStreamTvalid && sAxiStreamTlast) begin
          dropNext  = 1'b1;
          ovfInc    = 1'b1;
          stateNext = ACCEPT;
        end else begin
          stateNext = DISCARD;
        end
      end
      default: begin
        stateNext = SYNC;
      end
    endcase
  end

  // Write FSM state, write pointers and drop pulse.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state      <= SYNC;
      wrPtr      <= '0;
      wrCommit   <= '0;
      dropStrobe <= 1'b0;
    end else begin
      state      <= stateNext;
      wrPtr      <= wrPtrNext;
      wrCommit   <= wrCommitNext;
      dropStrobe <= dropNext;
    end
  end

  // Buffer write port (no reset: block-RAM style storage).
  always_ff @(posedge clk) begin
    if (memWe) begin
      mem[wrPtr[ADDR_WIDTH-1:0]] <= memWrData;
    end
  end

  // Read issue: only committed entries are readable. A read is launched only
  // if its data is guaranteed a slot in the two-entry output stage when it
  // lands one cycle later, counting the read already in flight.
  assign readable = (rdPtr != wrCommit);
  assign pop      = mAxiStreamTvalid && mAxiStreamTready;
  assign occ      = {1'b0, mAxiStreamTvalid} + {1'b0, skidValid} + {1'b0, rdValid};
  assign rdIssue  = readable && ((occ - {1'b0, pop}) <= 2'd1);

  // Registered memory read port.
  always_ff @(posedge clk) begin
    if (rdIssue) begin
      rdData <= mem[rdPtr[ADDR_WIDTH-1:0]];
    end
  end

  // Read pointer and read-data-valid tracking.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      rdPtr   <= '0;
      rdValid <= 1'b0;
    end else begin
      rdPtr   <= rdPtr + {{ADDR_WIDTH{1'b0}}, rdIssue};
      rdValid <= rdIssue;
    end
  end

  // Output head register plus skid entry; the head is frozen while stalled.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      mAxiStreamTvalid <= 1'b0;
      mAxiStreamTdata  <= 32'h0000_0000;
      mAxiStreamTkeep  <= 4'h0;
      mAxiStreamTlast  <= 1'b0;
      skidData         <= 37'h0;
      skidValid        <= 1'b0;
    end else if (!mAxiStreamTvalid || pop) begin
      if (skidValid) begin
        {mAxiStreamTlast, mAxiStreamTkeep, mAxiStreamTdata} <= skidData;
        mAxiStreamTvalid <= 1'b1;
        skidValid        <= rdValid;
        if (rdValid) begin
          skidData <= rdData;
        end
      end else if (rdValid) begin
        {mAxiStreamTlast, mAxiStreamTkeep, mAxiStreamTdata} <= rdData;
        mAxiStreamTvalid <= 1'b1;
      end else begin
        mAxiStreamTvalid <= 1'b0;
      end
    end else if (rdValid) begin
      skidData  <= rdData;
      skidValid <= 1'b1;
    end
  end

`ifdef AURORA_RX_FILTER_STATS_EN
  function automatic logic [15:0] satInc(input logic [15:0] cnt, input logic en);
    return (en && (cnt != 16'hFFFF)) ? cnt + 16'h0001 : cnt;
  endfunction

  // Saturating frame statistics.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      pktGoodCount     <= 16'h0000;
      pktCrcErrCount   <= 16'h0000;
      pktOverflowCount <= 16'h0000;
    end else begin
      pktGoodCount     <= satInc(pktGoodCount, goodInc);
      pktCrcErrCount   <= satInc(pktCrcErrCount, crcInc);
      pktOverflowCount <= satInc(pktOverflowCount, ovfInc);
    end
  end
`else
  logic unusedStats;
  assign unusedStats      = goodInc ^ crcInc ^ ovfInc;
  assign pktGoodCount     = 16'h0000;
  assign pktCrcErrCount   = 16'h0000;
  assign pktOverflowCount = 16'h0000;
`endif

endmodule

// File: doc/aurora_rx_packet_filter.md
# aurora_rx_packet_filter

Store-and-forward packet filter placed directly downstream of the Aurora link's 32-bit RX AXI stream, in the user-clock domain. It buffers each incoming frame, checks the CRC flags carried in tuser on the last beat, and releases only complete, CRC-good frames to a back-pressurable AXI stream. Frames that fail CRC or overflow the buffer are discarded whole, and each discard is counted.

## Interface
- `ADDR_WIDTH`, default 9: log2 of buffer depth in 37-bit entries.
- `clk`  in  1  single clock, the Aurora user clock; all logic is on the rising edge.
- `resetN`  in  1  asynchronous, active-low reset.
- `sAxiStreamTdata`  in  32  RX data from the link.
- `sAxiStreamTkeep`  in  4  byte enables, stored with the data.
- `sAxiStreamTuser`  in  8  bit1 = crcValid, bit0 = crcPass; sampled only on the tlast beat.
- `sAxiStreamTlast`  in  1  end of frame.
- `sAxiStreamTvalid`  in  1  beat qualifier. There is no tready: the source cannot be stalled.
- `mAxiStreamTdata`/`Tkeep`/`Tlast`  out  32/4/1  filtered frame output.
- `mAxiStreamTvalid`  out  1  output beat valid.
- `mAxiStreamTready`  in  1  downstream ready.
- `dropStrobe`  out  1  one-cycle pulse per discarded frame.
- `pktGoodCount`, `pktCrcErrCount`, `pktOverflowCount`  out  16 each  saturating frame counters.

## Operation
- Buffer: 2^ADDR_WIDTH entries of {last, keep, data}. It uses three ADDR_WIDTH+1-bit pointers:
  - `wrPtr`: speculative write pointer.
  - `wrCommit`: last committed write position.
  - `rdPtr`: read pointer.
- Full: `wrPtr - rdPtr == 2^ADDR_WIDTH`.
- Write FSM has three states: SYNC, ACCEPT, DISCARD. Reset enters SYNC.
- SYNC: discard all beats. A valid tlast beat moves to ACCEPT and is not counted. This resynchronises to frame boundaries after a reset that lands mid-frame.
- ACCEPT, on a valid beat when not full: write the entry and increment `wrPtr`.
  - On a tlast beat, the frame is good when tuser[1:0] == 2'b11. Good: `wrCommit <= wrPtr+1`, increment `pktGoodCount`.
  - Otherwise (including crcValid = 0): `wrPtr <= wrCommit`, pulse `dropStrobe`, increment `pktCrcErrCount`.
- ACCEPT, on a valid beat when full:
  - Rewind: `wrPtr <= wrCommit`.
  - If the beat is a tlast beat: pulse `dropStrobe`, increment `pktOverflowCount`, stay in ACCEPT.
  - Otherwise: go to DISCARD.
- DISCARD: drop beats. The tlast beat pulses `dropStrobe`, increments `pktOverflowCount` (CRC flags are ignored), and returns to ACCEPT.
- Read side: entries between `rdPtr` and `wrCommit` are readable. The memory has a registered read (block-RAM style). A two-entry output skid stage keeps throughput at 1 beat/cycle while tready is held high.
- AXI output rules: tdata, tkeep and tlast are held stable while tvalid && !tready. tvalid never drops without a handshake.
- A frame is never partially visible at the output: uncommitted entries are never read.
- Counters saturate at 16'hFFFF.
- Simultaneous commit and read in the same cycle are both honoured. Full and empty are evaluated from register values at the clock edge.

## Timing
- Reset values: `mAxiStreamTvalid`, `Tdata`, `Tkeep`, `Tlast`, `dropStrobe` and all counters are 0. Pointers are 0. FSM is in SYNC.
- Assertion of `resetN` takes effect asynchronously at any time and empties the buffer, including committed frames not yet read. Deassertion is released synchronously by the instantiating logic.
- Latency: if the tlast beat is sampled at edge N, the first beat of that frame shows `mAxiStreamTvalid` = 1 after edge N+2. Back-to-back frames stream with no idle cycles.
- `dropStrobe` and counter updates are visible after the edge that samples the offending tlast beat.

## Configuration
- `AURORA_RX_FILTER_STATS_EN` defined: the three counters are implemented as above.
- Not defined: counter registers are omitted and the count outputs are tied to 0. `dropStrobe` and filtering are unchanged.

## Test plan
- After reset, a 4-beat frame with data 1..4 and tuser = 2'b11 on the last beat: discarded because the FSM is in SYNC. The next identical frame appears at the output as 1..4 with tlast on beat 4, starting 2 cycles after its input tlast. `pktGoodCount` = 1.
- A frame ending with tuser = 2'b01, then a good frame: only the good frame is output, `dropStrobe` pulses once, `pktCrcErrCount` = 1. A frame ending with tuser = 2'b10 also increments `pktCrcErrCount`.
- ADDR_WIDTH = 4, `mAxiStreamTready` = 0, a 10-beat good frame followed by a 10-beat frame:
  - the first frame is held;
  - the second frame overflows, `pktOverflowCount` = 1;
  - after raising tready, exactly the 10 beats of the first frame are output.
- Randomised `mAxiStreamTready` against 100 good frames of length 1..20: output matches input exactly, and data stays stable while stalled.
- `resetN` pulsed low mid-frame: outputs go to 0 immediately, the remainder of that frame is discarded by SYNC, and the subsequent good frame passes.
- With the macro undefined, a CRC-bad frame: `dropStrobe` pulses and all counts read 0.
